piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 26 ++
 rtl/piso_serializer.sv | 97 +++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for one serialized word; saturates at WIDTH-1.
module piso_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign tc = (bit_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt <= '0;
        end else if (inc && !tc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load side and framed serial output.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(WIDTH - 2);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("piso_serializer: WIDTH out of range");
        end
    endgenerate

    piso_state_e      state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic             cnt_tc;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             last_bit;
    logic             accept;

    // The bit on the wire is always the "leading" end of sreg.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last_bit     = (state == SHIFT) && cnt_tc;
    assign load_ready   = !rst && ((state == IDLE) || last_bit);
    assign accept       = load_valid && load_ready;
    assign cnt_clear    = accept || last_bit;
    assign cnt_inc      = (state == SHIFT) && !cnt_tc;
    assign sreg_shifted = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .bit_cnt (bit_cnt),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            sreg        <= load_data;
            ser_out     <= lead_bit(load_data);
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
            busy        <= 1'b1;
        end else if (cnt_inc) begin
            sreg        <= sreg_shifted;
            ser_out     <= lead_bit(sreg_shifted);
            frame_start <= 1'b0;
            frame_end   <= (bit_cnt == PENULT);
        end else begin
            // Idle, or last bit sent with no follow-on word.
            state       <= IDLE;
            sreg        <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end
    end

endmodule
